// File: rtl/alu_issue_stage_if.sv
// Operand/opcode bundle between decode, the ALU issue stage and EX; ALU_ILLEGAL_TRAP_EN adds out_illegal.
// slave = the issue stage itself, master = its environment (decode on the input side, EX on the output side).
interface alu_issue_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_aluop;
  logic                     in_is_rtype;
  logic [2:0]               in_funct3;
  logic                     in_funct7_5;
  logic [DATA_WIDTH-1:0]    in_srca;
  logic [DATA_WIDTH-1:0]    in_srcb;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [TAG_WIDTH-1:0]     out_tag;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic                     out_illegal;
`endif

  modport slave (
    input  in_valid, in_aluop, in_is_rtype, in_funct3, in_funct7_5, in_srca, in_srcb, in_tag,
    input  out_ready,
    output in_ready, out_valid, SrcA, SrcB, Operation, out_tag
`ifdef ALU_ILLEGAL_TRAP_EN
    , output out_illegal
`endif
  );

  modport master (
    output in_valid, in_aluop, in_is_rtype, in_funct3, in_funct7_5, in_srca, in_srcb, in_tag,
    output out_ready,
    input  in_ready, out_valid, SrcA, SrcB, Operation, out_tag
`ifdef ALU_ILLEGAL_TRAP_EN
    , input out_illegal
`endif
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decodes ALUOp/funct3/funct7 into the ALU Operation and issues operands via a 2-entry skid buffer (ALU_ILLEGAL_TRAP_EN: flag illegal decodes).
// Latency 1 cycle; in_ready is registered (= skid slot free), outputs hold while out_valid & ~out_ready.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  alu_issue_stage_if.slave bus
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = 4'b0100;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = 4'b0101;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = 4'b0110;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = 4'b0111;
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = 4'b1001;
  localparam logic [OPCODE_LENGTH-1:0] OP_BGE = 4'b1010;
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE = 4'b1100;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    srca;
    logic [DATA_WIDTH-1:0]    srcb;
    logic [OPCODE_LENGTH-1:0] op;
    logic [TAG_WIDTH-1:0]     tag;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic                     illegal;
`endif
  } entry_t;

  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_illegal;
  entry_t                   in_ent;
  entry_t                   main_q, main_d, skid_q, skid_d;
  logic                     main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic                     in_rdy_q, in_rdy_d;
  logic                     in_fire, out_fire;

  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (bus.in_aluop)
      2'b01: begin
        case (bus.in_funct3)
          3'b000:  dec_op = OP_EQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_SLT;
          3'b101:  dec_op = OP_BGE;
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        case (bus.in_funct3)
          // funct7[5] only selects SUB for R-type; on ADDI it is an immediate bit
          3'b000:  dec_op = (bus.in_is_rtype && bus.in_funct7_5) ? OP_SUB : OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = bus.in_funct7_5 ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          3'b111:  dec_op = OP_AND;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_op = OP_ADD;
    endcase
  end

  always_comb begin
    in_ent      = '0;
    in_ent.srca = bus.in_srca;
    in_ent.srcb = bus.in_srcb;
    in_ent.tag  = bus.in_tag;
`ifdef ALU_ILLEGAL_TRAP_EN
    in_ent.op      = dec_illegal ? OP_AND : dec_op;
    in_ent.illegal = dec_illegal;
`else
    in_ent.op      = dec_illegal ? OP_ADD : dec_op;
`endif
  end

  assign in_fire  = bus.in_valid && in_rdy_q;
  assign out_fire = main_vld_q && bus.out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_fire || !main_vld_q) begin
      // main slot frees up: promote the skid entry, new data backfills behind it
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = in_fire;
        if (in_fire) skid_d = in_ent;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_d = in_ent;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_d     = in_ent;
    end
    in_rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = main_vld_q;
  assign bus.SrcA      = main_q.srca;
  assign bus.SrcB      = main_q.srcb;
  assign bus.Operation = main_q.op;
  assign bus.out_tag   = main_q.tag;
`ifdef ALU_ILLEGAL_TRAP_EN
  assign bus.out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, skid backpressure, flush and mid-stream reset.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .TAG_WIDTH(5)) bus ();

  alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .TAG_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] aluop, input logic rt, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    bus.in_valid    = v;
    bus.in_aluop    = aluop;
    bus.in_is_rtype = rt;
    bus.in_funct3   = f3;
    bus.in_funct7_5 = f7;
    bus.in_srca     = a;
    bus.in_srcb     = b;
    bus.in_tag      = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    step();
    reset = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_operation", 32'(bus.Operation), 32'h0);
    chk("rst_srca",      bus.SrcA,           32'h0);
    chk("rst_srcb",      bus.SrcB,           32'h0);
    chk("rst_tag",       32'(bus.out_tag),   32'h0);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("rst_illegal",   32'(bus.out_illegal), 32'd0);
`endif

    // Decode stream, one op per cycle with EX always ready
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 1'b1, 3'b000, 1'b1, 32'd7, 32'd3, 5'd1);
    step();
    chk("sub_valid", 32'(bus.out_valid), 32'd1);
    chk("sub_op",    32'(bus.Operation), 32'h4);
    chk("sub_srca",  bus.SrcA,           32'd7);
    chk("sub_srcb",  bus.SrcB,           32'd3);
    chk("sub_tag",   32'(bus.out_tag),   32'd1);
    drive(1'b1, 2'b10, 1'b0, 3'b000, 1'b1, 32'h11, 32'h400, 5'd2);
    step();
    chk("addi_op",   32'(bus.Operation), 32'h2);
    chk("addi_tag",  32'(bus.out_tag),   32'd2);
    chk("addi_srcb", bus.SrcB,           32'h400);
    drive(1'b1, 2'b10, 1'b0, 3'b101, 1'b1, 32'h0, 32'h0, 5'd3);
    step();
    chk("srai_op", 32'(bus.Operation), 32'h9);
    drive(1'b1, 2'b10, 1'b1, 3'b101, 1'b0, 32'h0, 32'h0, 5'd4);
    step();
    chk("srl_op", 32'(bus.Operation), 32'h7);
    drive(1'b1, 2'b01, 1'b0, 3'b001, 1'b0, 32'h0, 32'h0, 5'd5);
    step();
    chk("bne_op", 32'(bus.Operation), 32'hC);
    drive(1'b1, 2'b01, 1'b0, 3'b101, 1'b0, 32'h0, 32'h0, 5'd6);
    step();
    chk("bge_op", 32'(bus.Operation), 32'hA);
    chk("bge_tag", 32'(bus.out_tag), 32'd6);
    drive(1'b1, 2'b01, 1'b0, 3'b010, 1'b0, 32'h0, 32'h0, 5'd7);
    step();
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("brill_op",  32'(bus.Operation),   32'h0);
    chk("brill_ill", 32'(bus.out_illegal), 32'd1);
`else
    chk("brill_op",  32'(bus.Operation),   32'h2);
`endif
    drive(1'b1, 2'b00, 1'b0, 3'b111, 1'b1, 32'h0, 32'h0, 5'd8);
    step();
    chk("mem_op", 32'(bus.Operation), 32'h2);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("mem_ill", 32'(bus.out_illegal), 32'd0);
`endif
    drive(1'b1, 2'b10, 1'b1, 3'b011, 1'b0, 32'h0, 32'h0, 5'd9);
    step();
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("sltu_op", 32'(bus.Operation), 32'h0);
`else
    chk("sltu_op", 32'(bus.Operation), 32'h2);
`endif
    drive(1'b1, 2'b10, 1'b1, 3'b110, 1'b0, 32'h0, 32'h0, 5'd10);
    step();
    chk("or_op", 32'(bus.Operation), 32'h1);
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("idle_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: three offered, two accepted, outputs frozen on the first
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 1'b1, 3'b111, 1'b0, 32'd100, 32'd1, 5'd10);
    step();
    chk("bp1_valid", 32'(bus.out_valid), 32'd1);
    chk("bp1_rdy",   32'(bus.in_ready),  32'd1);
    drive(1'b1, 2'b10, 1'b1, 3'b100, 1'b0, 32'd200, 32'd2, 5'd11);
    step();
    chk("bp2_rdy", 32'(bus.in_ready), 32'd0);
    chk("bp2_tag", 32'(bus.out_tag),  32'd10);
    drive(1'b1, 2'b10, 1'b1, 3'b001, 1'b0, 32'd300, 32'd3, 5'd12);
    step();
    step();
    chk("bp3_rdy",  32'(bus.in_ready),  32'd0);
    chk("bp3_tag",  32'(bus.out_tag),   32'd10);
    chk("bp3_srca", bus.SrcA,           32'd100);
    chk("bp3_op",   32'(bus.Operation), 32'h0);
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.out_ready = 1'b1;
    step();
    chk("dr1_valid", 32'(bus.out_valid), 32'd1);
    chk("dr1_tag",   32'(bus.out_tag),   32'd11);
    chk("dr1_srca",  bus.SrcA,           32'd200);
    chk("dr1_op",    32'(bus.Operation), 32'h3);
    chk("dr1_rdy",   32'(bus.in_ready),  32'd1);
    step();
    chk("dr2_valid", 32'(bus.out_valid), 32'd0);

    // Flush with both slots full and an input offered
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 32'd20, 32'd0, 5'd20);
    step();
    drive(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 32'd21, 32'd0, 5'd21);
    step();
    chk("fl_full_rdy", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 32'd22, 32'd0, 5'd22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_rdy",   32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("fl_after_valid", 32'(bus.out_valid), 32'd0);

    // Flush with one entry and an accepted input in the same cycle
    drive(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 32'd30, 32'd0, 5'd30);
    bus.out_ready = 1'b0;
    step();
    drive(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 32'd31, 32'd0, 5'd31);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.out_ready = 1'b1;
    chk("fl1_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("fl1_after_valid", 32'(bus.out_valid), 32'd0);

    // Reset while full, then restart streaming
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 1'b1, 3'b100, 1'b0, 32'h55, 32'h66, 5'd14);
    step();
    drive(1'b1, 2'b10, 1'b1, 3'b110, 1'b0, 32'h77, 32'h88, 5'd15);
    step();
    chk("rf_valid", 32'(bus.out_valid), 32'd1);
    chk("rf_op",    32'(bus.Operation), 32'h3);
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_op",    32'(bus.Operation), 32'h0);
    chk("mr_srca",  bus.SrcA,           32'h0);
    chk("mr_rdy",   32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 1'b1, 3'b001, 1'b0, 32'd9, 32'd4, 5'd5);
    step();
    drive(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0);
    chk("rs_valid", 32'(bus.out_valid), 32'd1);
    chk("rs_op",    32'(bus.Operation), 32'h6);
    chk("rs_srca",  bus.SrcA,           32'd9);
    chk("rs_tag",   32'(bus.out_tag),   32'd5);
    step();
    chk("rs_end_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
